// File: rtl/minmax_sched_pkg.sv
// Shared types and default sizing for the minmax_sched round-robin min/max scheduler.
// The optional idle-beat timeout is enabled with MINMAX_SCHED_TIMEOUT_EN.
package minmax_sched_pkg;

    localparam int W_DEF    = 2;
    localparam int NREQ_DEF = 2;
    localparam int CNTW_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index reached by stepping 'step' places upward from 'base', wrapping at n.
    function automatic int rr_next(input int base, input int step, input int n);
        return (base + step) % n;
    endfunction

endpackage

// File: rtl/minmax_sched_if.sv
// Requester streams, grants and result bus of minmax_sched bundled in one interface.
// master drives the frames and consumes results; slave is the scheduler.
interface minmax_sched_if #(
    parameter int W    = 2,
    parameter int NREQ = 2,
    parameter int CNTW = 4
);

    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   gnt;
    logic [NREQ*W-1:0] din;
    logic [NREQ-1:0]   in_valid;
    logic [NREQ-1:0]   in_last;
    logic [NREQ-1:0]   in_ready;
    logic [W-1:0]      res_min;
    logic [W-1:0]      res_max;
    logic [IDW-1:0]    res_id;
    logic [CNTW-1:0]   res_cnt;
    logic              res_valid;
    logic              res_err;

    modport master (
        output req, din, in_valid, in_last,
        input  gnt, in_ready, res_min, res_max, res_id, res_cnt, res_valid, res_err
    );

    modport slave (
        input  req, din, in_valid, in_last,
        output gnt, in_ready, res_min, res_max, res_id, res_cnt, res_valid, res_err
    );

endinterface

// File: rtl/minmax_acc.sv
// Running unsigned min/max accumulator shared by all requesters.
// load starts a new frame from d; upd folds d into the current extremes.
module minmax_acc
    import minmax_sched_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         upd,
    input  logic [W-1:0] d,
    output logic [W-1:0] min_r,
    output logic [W-1:0] max_r
);

    // Extremes register; ties keep the stored value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            min_r <= {W{1'b0}};
            max_r <= {W{1'b0}};
        end else if (load) begin
            min_r <= d;
            max_r <= d;
        end else if (upd) begin
            if (d < min_r) begin
                min_r <= d;
            end
            if (d > max_r) begin
                max_r <= d;
            end
        end
    end

endmodule

// File: rtl/minmax_sched.sv
// Round-robin scheduler feeding one requester frame at a time through minmax_acc.
// Optional idle-beat abort: define MINMAX_SCHED_TIMEOUT_EN (limit set by parameter TMO).
module minmax_sched
    import minmax_sched_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int NREQ = NREQ_DEF,
    parameter int CNTW = CNTW_DEF
`ifdef MINMAX_SCHED_TIMEOUT_EN
    ,
    parameter int TMO  = 8
`endif
) (
    input  logic            clk,
    input  logic            rst,
    minmax_sched_if.slave   bus
);

    localparam int IDW = $clog2(NREQ);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [NREQ-1:0]   gnt_r;
    logic [NREQ-1:0]   onehot_s;
    logic [IDW-1:0]    ptr_r;
    logic [IDW-1:0]    win_s;
    logic              grant_s;
    logic              finish_s;
    logic              beat_s;
    logic              last_s;
    logic              first_r;
    logic [CNTW-1:0]   cnt_r;
    logic [CNTW-1:0]   cnt_nxt_s;
    logic [W-1:0]      d_s;
    logic [W-1:0]      acc_min_s;
    logic [W-1:0]      acc_max_s;
    logic [W-1:0]      fin_min_s;
    logic [W-1:0]      fin_max_s;
    logic [W-1:0]      res_min_r;
    logic [W-1:0]      res_max_r;
    logic [IDW-1:0]    res_id_r;
    logic [CNTW-1:0]   res_cnt_r;
    logic              res_valid_r;

    // Round-robin pick: lowest step above the last winner wins, so scan steps downward.
    always_comb begin
        win_s = ptr_r;
        for (int k = NREQ; k >= 1; k--) begin
            for (int i = 0; i < NREQ; i++) begin
                win_s = (bus.req[i] && (rr_next(int'(ptr_r), k, NREQ) == i)) ? IDW'(i) : win_s;
            end
        end
    end

    assign onehot_s = {{(NREQ-1){1'b0}}, 1'b1} << win_s;

    // Granted channel's data, selected by the one-hot grant.
    always_comb begin
        d_s = {W{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            d_s = d_s | (bus.din[i*W +: W] & {W{gnt_r[i]}});
        end
    end

    // gnt is only non-zero in SCAN, so it doubles as in_ready.
    assign beat_s    = |(bus.in_valid & gnt_r);
    assign last_s    = |(bus.in_last & gnt_r);
    assign cnt_nxt_s = !beat_s ? cnt_r :
                       (cnt_r == {CNTW{1'b1}}) ? cnt_r : (cnt_r + {{(CNTW-1){1'b0}}, 1'b1});

`ifdef MINMAX_SCHED_TIMEOUT_EN
    localparam int TMOW = $clog2(TMO + 1);

    logic [TMOW-1:0] tmo_r;
    logic            tmo_hit_s;
    logic            err_s;
    logic            res_err_r;

    assign tmo_hit_s = (state_r == SCAN) && !beat_s && (tmo_r == TMOW'(TMO - 1));
    assign err_s     = tmo_hit_s && !(beat_s && last_s);

    // Idle-cycle counter, only counts while scanning without an accepted beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_r <= {TMOW{1'b0}};
        end else if ((state_r == SCAN) && !beat_s) begin
            tmo_r <= tmo_r + {{(TMOW-1){1'b0}}, 1'b1};
        end else begin
            tmo_r <= {TMOW{1'b0}};
        end
    end

    // Abort flag is captured with every result, so a normal frame clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_err_r <= 1'b0;
        end else if (finish_s) begin
            res_err_r <= err_s;
        end
    end

    assign bus.res_err = res_err_r;
`else
    assign bus.res_err = 1'b0;
`endif

    // FSM next state and one-edge control strobes.
    always_comb begin
        state_nxt_s = state_r;
        grant_s     = 1'b0;
        finish_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (|bus.req) begin
                    state_nxt_s = SCAN;
                    grant_s     = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SCAN: begin
                if (beat_s && last_s) begin
                    state_nxt_s = DONE;
                    finish_s    = 1'b1;
`ifdef MINMAX_SCHED_TIMEOUT_EN
                end else if (tmo_hit_s) begin
                    state_nxt_s = DONE;
                    finish_s    = 1'b1;
`endif
                end else begin
                    state_nxt_s = SCAN;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Final frame values including the beat accepted on the finishing edge; zero if none.
    always_comb begin
        fin_min_s = acc_min_s;
        fin_max_s = acc_max_s;
        if (beat_s && first_r) begin
            fin_min_s = d_s;
            fin_max_s = d_s;
        end else if (beat_s) begin
            fin_min_s = (d_s < acc_min_s) ? d_s : acc_min_s;
            fin_max_s = (d_s > acc_max_s) ? d_s : acc_max_s;
        end else if (first_r) begin
            fin_min_s = {W{1'b0}};
            fin_max_s = {W{1'b0}};
        end else begin
            fin_min_s = acc_min_s;
            fin_max_s = acc_max_s;
        end
    end

    minmax_acc #(
        .W (W)
    ) u_acc (
        .clk   (clk),
        .rst   (rst),
        .load  (beat_s && first_r),
        .upd   (beat_s && !first_r),
        .d     (d_s),
        .min_r (acc_min_s),
        .max_r (acc_max_s)
    );

    // Grant, pointer, frame bookkeeping and held result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_r       <= {NREQ{1'b0}};
            ptr_r       <= IDW'(NREQ - 1);
            first_r     <= 1'b1;
            cnt_r       <= {CNTW{1'b0}};
            res_valid_r <= 1'b0;
            res_min_r   <= {W{1'b0}};
            res_max_r   <= {W{1'b0}};
            res_id_r    <= {IDW{1'b0}};
            res_cnt_r   <= {CNTW{1'b0}};
        end else begin
            res_valid_r <= finish_s;
            if (grant_s) begin
                gnt_r   <= onehot_s;
                ptr_r   <= win_s;
                first_r <= 1'b1;
                cnt_r   <= {CNTW{1'b0}};
            end else begin
                gnt_r   <= finish_s ? {NREQ{1'b0}} : gnt_r;
                first_r <= beat_s ? 1'b0 : first_r;
                cnt_r   <= cnt_nxt_s;
            end
            if (finish_s) begin
                res_min_r <= fin_min_s;
                res_max_r <= fin_max_s;
                res_id_r  <= ptr_r;
                res_cnt_r <= cnt_nxt_s;
            end
        end
    end

    assign bus.gnt       = gnt_r;
    assign bus.in_ready  = gnt_r;
    assign bus.res_valid = res_valid_r;
    assign bus.res_min   = res_min_r;
    assign bus.res_max   = res_max_r;
    assign bus.res_id    = res_id_r;
    assign bus.res_cnt   = res_cnt_r;

endmodule
